// File: rtl/crank_wheel_emu.sv
// Purpose: 60-2 style crank trigger-wheel emulator producing a tooth square wave with a missing-tooth gap.
// Latency: wheel_out is registered one clk behind the pitch counter; first rise 2 clk after ena in IDLE.
// Backpressure: none on the tooth stream; pitch writes are held pending and acked at the next tooth boundary.
module crank_wheel_emu #(
    parameter int PERIOD_WIDTH = 24,
    parameter int TEETH        = 60,
    parameter int MISSING      = 2,
    parameter int MIN_PERIOD   = 4,
    parameter int RST_PERIOD   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    input  logic                    period_wr,
    output logic                    period_ack,
    output logic                    wheel_out,
    output logic [7:0]              tooth_idx,
    output logic                    rev_out,
    output logic                    busy
);

    localparam logic [PERIOD_WIDTH-1:0] ONE           = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P         = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] RST_P         = PERIOD_WIDTH'(RST_PERIOD);
    localparam logic [7:0]              LAST_TOOTH    = 8'(TEETH - 1);
    localparam logic [7:0]              FIRST_MISSING = 8'(TEETH - MISSING);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [PERIOD_WIDTH-1:0] pc;
    logic [PERIOD_WIDTH-1:0] pc_nxt;
    logic [PERIOD_WIDTH-1:0] act;
    logic [PERIOD_WIDTH-1:0] act_nxt;
    logic [PERIOD_WIDTH-1:0] pend;
    logic [PERIOD_WIDTH-1:0] pend_nxt;
    logic [PERIOD_WIDTH-1:0] period_clamped;
    logic                    pend_flag;
    logic                    pend_flag_nxt;
    logic [7:0]              tooth_nxt;
    logic                    wheel_nxt;
    logic                    rev_nxt;
    logic                    ack_nxt;
    logic                    apply;
    logic                    running;
    logic                    boundary;
    logic                    real_tooth;
    logic                    high_phase;

    assign running        = (state != IDLE);
    assign busy           = running;
    assign boundary       = running && (pc == (act - ONE));
    assign real_tooth     = (tooth_idx < FIRST_MISSING);
    assign high_phase     = (pc < (act >> 1));
    assign period_clamped = (period_in < MIN_P) ? MIN_P : period_in;

    // Next-state, counter advance, pitch hand-over and tooth waveform decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        tooth_nxt = tooth_idx;
        wheel_nxt = 1'b0;
        rev_nxt   = 1'b0;
        apply     = 1'b0;

        case (state)
            IDLE: begin
                pc_nxt    = '0;
                tooth_nxt = '0;
                if (ena) begin
                    state_nxt = RUN;
                    // A pitch written while idle takes effect on the very first tooth.
                    apply     = pend_flag;
                end
            end
            RUN, STOPPING: begin
                // Missing teeth never drive high; real teeth are high for the first floor(act/2) counts.
                wheel_nxt = real_tooth && high_phase;
                rev_nxt   = (pc == '0) && (tooth_idx == '0);
                if (boundary) begin
                    pc_nxt    = '0;
                    tooth_nxt = (tooth_idx == LAST_TOOTH) ? 8'd0 : (tooth_idx + 8'd1);
                    apply     = pend_flag;
                end else begin
                    pc_nxt = pc + ONE;
                end

                if (state == RUN) begin
                    if (!ena) begin
                        state_nxt = STOPPING;
                    end
                end else begin
                    // Re-asserting ena before the boundary resumes without disturbing the tooth.
                    if (ena) begin
                        state_nxt = RUN;
                    end else if (boundary) begin
                        state_nxt = IDLE;
                        pc_nxt    = '0;
                        tooth_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
                tooth_nxt = '0;
            end
        endcase

        // The boundary consumes the pend value held before this cycle; a write in the
        // same cycle stays pending and is handed over at the following boundary.
        act_nxt       = apply ? pend : act;
        ack_nxt       = apply;
        pend_nxt      = period_wr ? period_clamped : pend;
        pend_flag_nxt = period_wr | (pend_flag & ~apply);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, pitch registers and registered outputs; reset drops any pending pitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            tooth_idx  <= '0;
            act        <= RST_P;
            pend       <= RST_P;
            pend_flag  <= 1'b0;
            wheel_out  <= 1'b0;
            rev_out    <= 1'b0;
            period_ack <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            tooth_idx  <= tooth_nxt;
            act        <= act_nxt;
            pend       <= pend_nxt;
            pend_flag  <= pend_flag_nxt;
            wheel_out  <= wheel_nxt;
            rev_out    <= rev_nxt;
            period_ack <= ack_nxt;
        end
    end

endmodule
